// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin two-requester UART transmitter paced by an external baudtick
module uart_tx_scheduler #(
  parameter int DATAWIDTH = 8,
  parameter int STOPBITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baudtick,
  input  logic                 req0,
  input  logic [DATAWIDTH-1:0] data0,
  input  logic                 req1,
  input  logic [DATAWIDTH-1:0] data1,
  output logic                 ack0,
  output logic                 ack1,
  output logic                 tx,
  output logic                 busy
);
  localparam int BW = $clog2(DATAWIDTH + 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t               state_q, state_d;
  logic [DATAWIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [1:0]           stop_q, stop_d;
  logic                 last_q, last_d;
  logic                 tx_q, tx_d;
  logic                 arb, gnt0, gnt1;
  always_comb begin
    arb     = rst_n && baudtick && (state_q == IDLE || (state_q == STOP && stop_q == 2'(STOPBITS)));
    gnt1    = arb && req1 && (!req0 || !last_q);
    gnt0    = arb && req0 && !gnt1;
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    last_d  = last_q;
    tx_d    = tx_q;
    if (gnt0 || gnt1) begin
      state_d = START;
      shift_d = gnt1 ? data1 : data0;
      bit_d   = '0;
      stop_d  = '0;
      last_d  = gnt1;
      tx_d    = 1'b0;
    end else if (baudtick) begin
      case (state_q)
        START: begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          bit_d   = BW'(1);
          state_d = DATA;
        end
        DATA: begin
          tx_d    = bit_q == BW'(DATAWIDTH) ? 1'b1 : shift_q[0];
          shift_d = shift_q >> 1;
          bit_d   = bit_q == BW'(DATAWIDTH) ? '0 : bit_q + BW'(1);
          stop_d  = bit_q == BW'(DATAWIDTH) ? 2'd1 : stop_q;
          state_d = bit_q == BW'(DATAWIDTH) ? STOP : DATA;
        end
        STOP: begin
          stop_d  = stop_q == 2'(STOPBITS) ? 2'd0 : stop_q + 2'd1;
          state_d = stop_q == 2'(STOPBITS) ? IDLE : STOP;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      stop_q  <= '0;
      last_q  <= 1'b1;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      last_q  <= last_d;
      tx_q    <= tx_d;
    end
  end
  assign ack0 = gnt0;
  assign ack1 = gnt1;
  assign tx   = tx_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: table-driven frame/arbitration vectors plus reset and tick-burst sequences
module tb_uart_tx_scheduler;
  logic       clk = 1'b0, rst_n = 1'b0, baudtick = 1'b0, req0 = 1'b0, req1 = 1'b0;
  logic [7:0] data0 = 8'h00, data1 = 8'h00;
  logic       a0_1, a1_1, tx_1, busy_1, a0_2, a1_2, tx_2, busy_2;
  logic       sel = 1'b0;
  logic       a0, a1, tx, busy;
  always #5 clk = ~clk;
  uart_tx_scheduler #(.DATAWIDTH(8), .STOPBITS(1)) dut (
    .clk(clk), .rst_n(rst_n), .baudtick(baudtick), .req0(req0), .data0(data0),
    .req1(req1), .data1(data1), .ack0(a0_1), .ack1(a1_1), .tx(tx_1), .busy(busy_1));
  uart_tx_scheduler #(.DATAWIDTH(8), .STOPBITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .baudtick(baudtick), .req0(req0), .data0(data0),
    .req1(req1), .data1(data1), .ack0(a0_2), .ack1(a1_2), .tx(tx_2), .busy(busy_2));
  assign a0   = sel ? a0_2 : a0_1;
  assign a1   = sel ? a1_2 : a1_1;
  assign tx   = sel ? tx_2 : tx_1;
  assign busy = sel ? busy_2 : busy_1;
  typedef struct packed {
    logic [1:0]      sb;
    logic [2:0][7:0] b0;
    logic [1:0]      n0;
    logic [2:0][7:0] b1;
    logic [1:0]      n1;
    logic [3:0][7:0] ord;
    logic [2:0]      no;
  } vec_t;
  vec_t       vecs[7];
  logic [7:0] q0[$], q1[$], order[$];
  bit         txlog[$];
  bit         prev_bt;
  int         tests = 0, fails = 0, busy_cnt, ack_both, ack_notick;
  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic step(input bit bt, input bit rn);
    @(negedge clk);
    rst_n    = rn;
    baudtick = bt;
    req0     = q0.size() > 0;
    data0    = req0 ? q0[0] : 8'h00;
    req1     = q1.size() > 0;
    data1    = req1 ? q1[0] : 8'h00;
    #1;
    if (prev_bt) txlog.push_back(tx);
    prev_bt = bt;
    if (busy === 1'b1) busy_cnt++;
    if (a0 && a1) ack_both++;
    if ((a0 || a1) && !bt) ack_notick++;
    if (a0) begin
      order.push_back(data0);
      q0.delete(0);
    end
    if (a1) begin
      order.push_back(data1);
      q1.delete(0);
    end
  endtask
  task automatic clear_logs();
    order.delete();
    txlog.delete();
    prev_bt    = 1'b0;
    busy_cnt   = 0;
    ack_both   = 0;
    ack_notick = 0;
  endtask
  task automatic chk_frames(input string nm, input logic [3:0][7:0] ob, input int no, input int sb);
    bit e[$];
    int m;
    m = 0;
    for (int k = 0; k < no; k++) begin
      e.push_back(1'b0);
      for (int i = 0; i < 8; i++) e.push_back(ob[k][i]);
      for (int s = 0; s < sb; s++) e.push_back(1'b1);
    end
    if (txlog.size() < e.size()) m += e.size() - txlog.size();
    foreach (txlog[i]) if (txlog[i] !== (i < e.size() ? e[i] : 1'b1)) m++;
    chk(nm, m, 0);
  endtask
  initial begin
    vecs[0] = '{sb: 2'd1, b0: 24'h0000A5, n0: 2'd1, b1: 24'h0, n1: 2'd0, ord: 32'h000000A5, no: 3'd1};
    vecs[1] = '{sb: 2'd1, b0: 24'h000011, n0: 2'd1, b1: 24'h000022, n1: 2'd1, ord: 32'h00002211, no: 3'd2};
    vecs[2] = '{sb: 2'd1, b0: 24'h030201, n0: 2'd3, b1: 24'h000080, n1: 2'd1, ord: 32'h03028001, no: 3'd4};
    vecs[3] = '{sb: 2'd2, b0: 24'h0000FF, n0: 2'd1, b1: 24'h0, n1: 2'd0, ord: 32'h000000FF, no: 3'd1};
    vecs[4] = '{sb: 2'd1, b0: 24'h0, n0: 2'd0, b1: 24'h00003C, n1: 2'd1, ord: 32'h0000003C, no: 3'd1};
    vecs[5] = '{sb: 2'd2, b0: 24'h004281, n0: 2'd2, b1: 24'h0, n1: 2'd0, ord: 32'h00004281, no: 3'd2};
    vecs[6] = '{sb: 2'd1, b0: 24'h0, n0: 2'd0, b1: 24'h0055C3, n1: 2'd2, ord: 32'h000055C3, no: 3'd2};
    clear_logs();
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("reset_tx", int'(tx), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_ack", int'(a0 | a1), 0);
    foreach (vecs[v]) begin
      sel = vecs[v].sb == 2'd2;
      clear_logs();
      step(1'b0, 1'b0);
      for (int i = 0; i < int'(vecs[v].n0); i++) q0.push_back(vecs[v].b0[i]);
      for (int i = 0; i < int'(vecs[v].n1); i++) q1.push_back(vecs[v].b1[i]);
      for (int c = 0; c < 4 * (int'(vecs[v].no) * (9 + int'(vecs[v].sb)) + 4); c++) step(c % 4 == 3, 1'b1);
      chk($sformatf("v%0d_count", v), order.size(), int'(vecs[v].no));
      for (int i = 0; i < int'(vecs[v].no); i++)
        chk($sformatf("v%0d_order%0d", v, i), i < order.size() ? int'(order[i]) : -1, int'(vecs[v].ord[i]));
      chk_frames($sformatf("v%0d_txbits", v), vecs[v].ord, int'(vecs[v].no), int'(vecs[v].sb));
      chk($sformatf("v%0d_busy_cycles", v), busy_cnt, int'(vecs[v].no) * (9 + int'(vecs[v].sb)) * 4);
      chk($sformatf("v%0d_ack_both", v), ack_both, 0);
      chk($sformatf("v%0d_ack_notick", v), ack_notick, 0);
      chk($sformatf("v%0d_drained", v), q0.size() + q1.size(), 0);
    end
    sel = 1'b0;
    clear_logs();
    step(1'b0, 1'b0);
    q0.push_back(8'h5A);
    q0.push_back(8'h5A);
    for (int c = 0; c < 21; c++) step(c % 4 == 3, 1'b1);
    chk("rst_pre_acks", order.size(), 1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("rst_mid_tx", int'(tx), 1);
    chk("rst_mid_busy", int'(busy), 0);
    clear_logs();
    for (int c = 23; c < 23 + 56; c++) step(c % 4 == 3, 1'b1);
    chk("rst_reack", order.size(), 1);
    chk("rst_reack_byte", order.size() > 0 ? int'(order[0]) : -1, 8'h5A);
    chk_frames("rst_resend_bits", 32'h0000005A, 1, 1);
    chk("rst_busy_cycles", busy_cnt, 40);
    clear_logs();
    step(1'b0, 1'b0);
    q0.push_back(8'hB4);
    for (int c = 0; c < 56; c++) step(c % 4 == 3 || (c >= 17 && c <= 19), 1'b1);
    chk("burst_count", order.size(), 1);
    chk_frames("burst_bits", 32'h000000B4, 1, 1);
    chk("burst_busy_cycles", busy_cnt, 32);
    chk("burst_ack_notick", ack_notick, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 Parameter DATAWIDTH, default 8, meaning payload bits per frame.
REQ-002 Parameter STOPBITS, default 1, meaning stop-bit periods per frame; legal values 1 or 2.
REQ-003 Port clk  input  1  system clock; all logic on rising edge.
REQ-004 Port rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port baudtick  input  1  one-cycle pulse per bit period, from the baud generator accumulator carry.
REQ-006 Port req0  input  1  requester 0 has a byte pending.
REQ-007 Port data0  input  DATAWIDTH  requester 0 byte; stable while req0 high and ack0 low.
REQ-008 Port req1  input  1  requester 1 has a byte pending.
REQ-009 Port data1  input  DATAWIDTH  requester 1 byte; same rules as data0.
REQ-010 Port ack0  output  1  one-cycle pulse: data0 latched, requester 0 may change data or drop req0.
REQ-011 Port ack1  output  1  one-cycle pulse, same meaning for requester 1.
REQ-012 Port tx  output  1  serial line, idle high, registered.
REQ-013 Port busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, START, DATA, STOP; tx, state and bit counters change only in cycles where baudtick=1, except ack pulses and reset.
REQ-015 In IDLE with baudtick=1 and any req high, the block SHALL grant one requester, latch its data into the shift register, pulse its ack in that cycle, drive tx=0 from the next cycle, and enter START.
REQ-016 In IDLE, a req without baudtick SHALL produce no grant and no ack; tx stays 1.
REQ-017 Arbitration SHALL be round-robin: with both req high, grant the requester not granted most recently; with one req high, grant it regardless of history.
REQ-018 The last-grant pointer SHALL update only on a grant; after reset it SHALL favour requester 0.
REQ-019 At most one ack SHALL be high in any cycle.
REQ-020 START on baudtick: tx=bit0 and enter DATA with bit index 1.
REQ-021 DATA on baudtick: drive the next bit, LSB first; on the baudtick after bit DATAWIDTH-1 is driven, tx=1 and enter STOP.
REQ-022 STOP SHALL last STOPBITS baudtick periods with tx=1.
REQ-023 On the baudtick ending the final stop period, if any req is high, the block SHALL arbitrate and start the next frame in that same cycle (tx=0 next cycle, ack pulsed, state START); otherwise it enters IDLE.
REQ-024 Each bit, including the start bit and each stop bit, SHALL last exactly one baudtick-to-baudtick interval.
REQ-025 A req rising mid-frame SHALL be held pending and not acked until the next arbitration point.
REQ-026 busy SHALL rise in the cycle after the grant and fall in the cycle after the IDLE entry.
REQ-027 Two consecutive baudtick cycles SHALL each be treated as a separate bit boundary.

Reset
REQ-028 With rst_n low at a clock edge, the next cycle SHALL show tx=1, ack0=0, ack1=0, busy=0, state=IDLE, last-grant favouring requester 0, and bit and stop counters cleared.
REQ-029 Reset mid-frame SHALL discard the latched byte without any further ack; a requester still holding req SHALL be served as new after reset.

Verification
REQ-030 baudtick every 4 clocks, req0 with data0=0xA5 -> ack0 one pulse; tx = 0,1,0,1,0,0,1,0,1 then 1, each bit 4 clocks; busy high for 40 clocks.
REQ-031 req0 and req1 rise in the same cycle with 0x11 and 0x22 and are held -> frame 0x11 (ack0) then 0x22 (ack1) back-to-back, no idle bit between frames.
REQ-032 req0 held continuously with successive bytes 0x01, 0x02, 0x03 while req1 pulses once with 0x80 -> order 0x01, 0x80, 0x02, 0x03; ack pulses alternate correctly.
REQ-033 STOPBITS=2, byte 0xFF -> start 0, eight 1s, then stop level held 2 bit periods before next start or idle.
REQ-034 rst_n low for 1 cycle during bit 3 of 0x5A -> tx=1 and busy=0 next cycle; held req0 re-acked at the next baudtick and 0x5A resent in full.
REQ-035 baudtick held high 3 consecutive cycles during DATA -> three bit advances, one per cycle; bit order preserved.
